// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller FIFOs.
// Optional stall counters are built when SDRAM_ARB_PERF_EN is defined.
module sdram_port_arbiter #(
    parameter int TAG_DEPTH = 8,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [23:0]       p0_addr_i,
    input  logic [15:0]       p0_data_i,
    output logic              p0_ack_o,
    output logic [15:0]       p0_rdata_o,
    output logic              p0_rvalid_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [23:0]       p1_addr_i,
    input  logic [15:0]       p1_data_i,
    output logic              p1_ack_o,
    output logic [15:0]       p1_rdata_o,
    output logic              p1_rvalid_o,
    output logic [40:0]       writer_d_o,
    output logic              writer_enq_o,
    input  logic              writer_full_i,
    input  logic [15:0]       reader_q_i,
    output logic              reader_deq_o,
    input  logic              reader_empty_i,
    output logic              orphan_err_o,
    output logic [PERF_W-1:0] p0_stall_cnt_o,
    output logic [PERF_W-1:0] p1_stall_cnt_o
);

    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic {
        ARB,
        HOLD
    } cmd_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DELIVER
    } ret_state_t;

    cmd_state_t cmd_state, cmd_next;
    ret_state_t ret_state, ret_next;

    logic [TAG_DEPTH-1:0] tag_mem;
    logic [AW:0]          tag_wp, tag_rp;
    logic                 tag_full, tag_empty, tag_head;
    logic                 tag_push, tag_pop;

    logic        elig0, elig1, grant, gnt_sel, gnt_we;
    logic [40:0] gnt_word;
    logic        last_grant;

    logic        capture, deliver;
    logic [15:0] rdata_q;
    logic        cap_tag, cap_ok;

    // Tag FIFO status; the extra pointer bit separates full from empty
    assign tag_empty = (tag_wp == tag_rp);
    assign tag_full  = (tag_wp[AW] != tag_rp[AW]) &&
                       (tag_wp[AW-1:0] == tag_rp[AW-1:0]);
    assign tag_head  = tag_mem[tag_rp[AW-1:0]];

    // Tag FIFO pointers; simultaneous push and pop both take effect
    always_ff @(posedge clk) begin
        if (reset_i) begin
            tag_wp <= '0;
            tag_rp <= '0;
        end else begin
            if (tag_push) tag_wp <= tag_wp + 1'b1;
            if (tag_pop)  tag_rp <= tag_rp + 1'b1;
        end
    end

    // Tag storage: the issuing port id of each outstanding read
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wp[AW-1:0]] <= gnt_sel;
    end

    // Command FSM state register
    always_ff @(posedge clk) begin
        if (reset_i) cmd_state <= ARB;
        else         cmd_state <= cmd_next;
    end

    // Command FSM next state: every grant is followed by one HOLD cycle
    always_comb begin
        cmd_next = cmd_state;
        unique case (cmd_state)
            ARB:  if (grant) cmd_next = HOLD;
            HOLD: cmd_next = ARB;
            default: cmd_next = ARB;
        endcase
    end

    // Command FSM outputs: eligibility and round-robin pick
    always_comb begin
        elig0    = p0_req_i && !writer_full_i && (p0_we_i || !tag_full);
        elig1    = p1_req_i && !writer_full_i && (p1_we_i || !tag_full);
        grant    = (cmd_state == ARB) && (elig0 || elig1);
        gnt_sel  = (elig0 && elig1) ? ~last_grant : elig1;
        gnt_we   = gnt_sel ? p1_we_i : p0_we_i;
        gnt_word = gnt_sel ? {p1_we_i, p1_addr_i, p1_data_i}
                           : {p0_we_i, p0_addr_i, p0_data_i};
        tag_push = grant && !gnt_we;
    end

    // Registered command strobe, word, acks and round-robin history
    always_ff @(posedge clk) begin
        if (reset_i) begin
            writer_enq_o <= 1'b0;
            writer_d_o   <= '0;
            p0_ack_o     <= 1'b0;
            p1_ack_o     <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            writer_enq_o <= grant;
            p0_ack_o     <= grant && !gnt_sel;
            p1_ack_o     <= grant && gnt_sel;
            if (grant) begin
                writer_d_o <= gnt_word;
                last_grant <= gnt_sel;
            end
        end
    end

    // Read-return FSM state register
    always_ff @(posedge clk) begin
        if (reset_i) ret_state <= R_IDLE;
        else         ret_state <= ret_next;
    end

    // Read-return FSM next state: dequeue, capture, deliver
    always_comb begin
        ret_next = ret_state;
        unique case (ret_state)
            R_IDLE:    if (!reader_empty_i) ret_next = R_WAIT;
            R_WAIT:    ret_next = R_DELIVER;
            R_DELIVER: ret_next = R_IDLE;
            default:   ret_next = R_IDLE;
        endcase
    end

    // Read-return FSM outputs
    always_comb begin
        reader_deq_o = (ret_state == R_IDLE) && !reader_empty_i;
        capture      = (ret_state == R_WAIT);
        deliver      = (ret_state == R_DELIVER);
        tag_pop      = deliver && cap_ok;
        p0_rvalid_o  = deliver && cap_ok && !cap_tag;
        p1_rvalid_o  = deliver && cap_ok && cap_tag;
    end

    // Capture returned data with its tag; untagged data is dropped
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rdata_q      <= '0;
            cap_tag      <= 1'b0;
            cap_ok       <= 1'b0;
            orphan_err_o <= 1'b0;
        end else if (capture) begin
            cap_tag <= tag_head;
            cap_ok  <= !tag_empty;
            if (tag_empty) orphan_err_o <= 1'b1;
            else           rdata_q      <= reader_q_i;
        end
    end

    assign p0_rdata_o = rdata_q;
    assign p1_rdata_o = rdata_q;

`ifdef SDRAM_ARB_PERF_EN
    logic [PERF_W-1:0] stall0, stall1;

    // Saturating count of cycles a port waits with no ack
    always_ff @(posedge clk) begin
        if (reset_i) begin
            stall0 <= '0;
            stall1 <= '0;
        end else begin
            if (p0_req_i && !p0_ack_o && stall0 != '1)
                stall0 <= stall0 + 1'b1;
            if (p1_req_i && !p1_ack_o && stall1 != '1)
                stall1 <= stall1 + 1'b1;
        end
    end

    assign p0_stall_cnt_o = stall0;
    assign p1_stall_cnt_o = stall1;
`else
    assign p0_stall_cnt_o = '0;
    assign p1_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter.
// Built with TAG_DEPTH = 2 so the tag-full case is reachable.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        reset_i;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [23:0] p0_addr_i, p1_addr_i;
    logic [15:0] p0_data_i, p1_data_i;
    logic        p0_ack_o, p1_ack_o, p0_rvalid_o, p1_rvalid_o;
    logic [15:0] p0_rdata_o, p1_rdata_o;
    logic [40:0] writer_d_o;
    logic        writer_enq_o, writer_full_i;
    logic [15:0] reader_q_i;
    logic        reader_deq_o, reader_empty_i;
    logic        orphan_err_o;
    logic [15:0] p0_stall_cnt_o, p1_stall_cnt_o;

    int nerr = 0;
    int nchk = 0;

    logic [15:0] rmem [64];
    int n_push = 0;
    int n_pop  = 0;

    sdram_port_arbiter #(.TAG_DEPTH(2), .PERF_W(16)) dut (
        .clk(clk),
        .reset_i(reset_i),
        .p0_req_i(p0_req_i),
        .p0_we_i(p0_we_i),
        .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i),
        .p0_ack_o(p0_ack_o),
        .p0_rdata_o(p0_rdata_o),
        .p0_rvalid_o(p0_rvalid_o),
        .p1_req_i(p1_req_i),
        .p1_we_i(p1_we_i),
        .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i),
        .p1_ack_o(p1_ack_o),
        .p1_rdata_o(p1_rdata_o),
        .p1_rvalid_o(p1_rvalid_o),
        .writer_d_o(writer_d_o),
        .writer_enq_o(writer_enq_o),
        .writer_full_i(writer_full_i),
        .reader_q_i(reader_q_i),
        .reader_deq_o(reader_deq_o),
        .reader_empty_i(reader_empty_i),
        .orphan_err_o(orphan_err_o),
        .p0_stall_cnt_o(p0_stall_cnt_o),
        .p1_stall_cnt_o(p1_stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller read FIFO model: data appears the cycle after deq
    assign reader_empty_i = (n_push == n_pop);

    always @(posedge clk) begin
        if (reader_deq_o) begin
            reader_q_i <= rmem[n_pop];
            n_pop      <= n_pop + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ret_push(input logic [15:0] v);
        rmem[n_push] = v;
        n_push++;
    endtask

    task automatic drop_reqs();
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
    endtask

    task automatic do_reset();
        drop_reqs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic issue(input int port, input logic we,
                         input logic [23:0] addr, input logic [15:0] data,
                         input string tag);
        if (port == 0) begin
            p0_req_i = 1'b1; p0_we_i = we;
            p0_addr_i = addr; p0_data_i = data;
        end else begin
            p1_req_i = 1'b1; p1_we_i = we;
            p1_addr_i = addr; p1_data_i = data;
        end
        tick();
        check_eq({tag, "_ack"}, (port == 0) ? p0_ack_o : p1_ack_o, 1);
        check_eq({tag, "_d"}, writer_d_o, {we, addr, data});
        drop_reqs();
        tick();
    endtask

    logic [1:0]  rr_exp [8];
    logic [15:0] base0, base1, diff;
    logic [4:0]  ack_exp;

    initial begin
        reset_i = 1'b1;
        p0_req_i = 0; p0_we_i = 0; p0_addr_i = 0; p0_data_i = 0;
        p1_req_i = 0; p1_we_i = 0; p1_addr_i = 0; p1_data_i = 0;
        writer_full_i = 0;
        reader_q_i = 0;
        do_reset();

        // reset state
        check_eq("rst_enq", writer_enq_o, 0);
        check_eq("rst_d", writer_d_o, 0);
        check_eq("rst_acks", {p1_ack_o, p0_ack_o}, 0);
        check_eq("rst_rvalid", {p1_rvalid_o, p0_rvalid_o}, 0);
        check_eq("rst_rdata", {p1_rdata_o, p0_rdata_o}, 0);
        check_eq("rst_orphan", orphan_err_o, 0);
        check_eq("rst_deq", reader_deq_o, 0);
        check_eq("rst_stall", {p1_stall_cnt_o, p0_stall_cnt_o}, 0);

        // single write, then a HOLD cycle with no strobe
        p0_req_i = 1; p0_we_i = 1;
        p0_addr_i = 24'h001000; p0_data_i = 16'h1000;
        tick();
        check_eq("wr_enq", writer_enq_o, 1);
        check_eq("wr_d", writer_d_o, 41'h1_001000_1000);
        check_eq("wr_acks", {p1_ack_o, p0_ack_o}, 2'b01);
        drop_reqs();
        tick();
        check_eq("wr_hold_enq", writer_enq_o, 0);
        check_eq("wr_hold_ack", p0_ack_o, 0);

        // round robin from reset: p0 first, one grant per two cycles
        do_reset();
        rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00,
                   2'b01, 2'b00, 2'b10, 2'b00};
        p0_req_i = 1; p0_we_i = 1; p0_addr_i = 24'h000011; p0_data_i = 16'hAAAA;
        p1_req_i = 1; p1_we_i = 1; p1_addr_i = 24'h000022; p1_data_i = 16'hBBBB;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("rr_%0d", i), {p1_ack_o, p0_ack_o}, rr_exp[i]);
            if (i == 2)
                check_eq("rr_d_p1", writer_d_o, 41'h1_000022_BBBB);
        end
        drop_reqs();
        tick();

        // read routing back to the issuing port, in order
        do_reset();
        issue(1, 0, 24'h002000, 16'h0000, "rd_p1");
        issue(0, 0, 24'h001000, 16'h0000, "rd_p0");
        ret_push(16'h2000);
        ret_push(16'h1000);
        #1;
        check_eq("rt_deq1", reader_deq_o, 1);
        tick();
        tick();
        check_eq("rt_v1", {p1_rvalid_o, p0_rvalid_o}, 2'b10);
        check_eq("rt_d1", p1_rdata_o, 16'h2000);
        tick();
        check_eq("rt_deq2", reader_deq_o, 1);
        tick();
        tick();
        check_eq("rt_v2", {p1_rvalid_o, p0_rvalid_o}, 2'b01);
        check_eq("rt_d2", p0_rdata_o, 16'h1000);
        tick();
        check_eq("rt_idle", {reader_deq_o, p1_rvalid_o, p0_rvalid_o}, 0);
        check_eq("rt_orphan", orphan_err_o, 0);

        // backpressure: ten full cycles, ack one cycle after release
        base0 = p0_stall_cnt_o;
        base1 = p1_stall_cnt_o;
        writer_full_i = 1;
        p0_req_i = 1; p0_we_i = 1;
        p0_addr_i = 24'h000044; p0_data_i = 16'h4444;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("bp_%0d", i), {writer_enq_o, p0_ack_o}, 0);
        end
        writer_full_i = 0;
        tick();
        check_eq("bp_rel", {writer_enq_o, p0_ack_o}, 2'b11);
        drop_reqs();
`ifdef SDRAM_ARB_PERF_EN
        diff = p0_stall_cnt_o - base0;
        check_eq("bp_stall0", diff, 11);
        diff = p1_stall_cnt_o - base1;
        check_eq("bp_stall1", diff, 0);
`else
        check_eq("bp_stall_off", {p1_stall_cnt_o, p0_stall_cnt_o}, 0);
`endif
        tick();

        // tag full: third read waits, other port's write still goes
        do_reset();
        issue(0, 0, 24'h000010, 16'h0000, "tf_rd1");
        issue(0, 0, 24'h000020, 16'h0000, "tf_rd2");
        p0_req_i = 1; p0_we_i = 0; p0_addr_i = 24'h000030; p0_data_i = 0;
        p1_req_i = 1; p1_we_i = 1; p1_addr_i = 24'h003000; p1_data_i = 16'hBEEF;
        tick();
        check_eq("tf_wr_acks", {p1_ack_o, p0_ack_o}, 2'b10);
        check_eq("tf_wr_d", writer_d_o, 41'h1_003000_BEEF);
        p1_req_i = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("tf_wait_%0d", i), p0_ack_o, 0);
        end
        ret_push(16'h5555);
        ack_exp = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            check_eq($sformatf("tf_ack_%0d", i), p0_ack_o, ack_exp[i]);
            if (i == 2) begin
                check_eq("tf_rv", p0_rvalid_o, 1);
                check_eq("tf_rd", p0_rdata_o, 16'h5555);
            end
        end
        check_eq("tf_rd3_d", writer_d_o, 41'h0_000030_0000);
        drop_reqs();
        tick();

        // orphan: reset with a read outstanding, then data arrives
        do_reset();
        issue(1, 0, 24'h000777, 16'h0000, "or_rd");
        reset_i = 1;
        tick();
        reset_i = 0;
        check_eq("or_pre", orphan_err_o, 0);
        ret_push(16'h7777);
        #1;
        check_eq("or_deq", reader_deq_o, 1);
        tick();
        tick();
        check_eq("or_rv", {p1_rvalid_o, p0_rvalid_o}, 0);
        check_eq("or_err", orphan_err_o, 1);
        tick();
        check_eq("or_drained", reader_empty_i, 1);
        tick();
        check_eq("or_sticky", orphan_err_o, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
